coef_bank_seq: RTL and testbench

//  Multi-profile IIR biquad coefficient bank with a built-in readout sequencer; successor to the fixed 200 Hz coefficient mux.
//  On start, streams the 5 coefficients of the selected profile (a1,a2,b0,b1,b2) one per clock to the serial biquad MAC.

---
 rtl/coef_pkg.sv | 38 +++
 rtl/coef_regfile.sv | 76 +++++++
 rtl/coef_bank_seq.sv | 135 +++++++++++++
 tb/tb_coef_bank_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_pkg.sv
// Shared constants for the biquad coefficient bank: coefficient indices,
// Q5.20 default coefficients and the readout sequencer state encoding.
package coef_pkg;

    localparam int NCOEF = 5;
    localparam int DEF_W = 25;

    localparam logic [2:0] IDX_A1 = 3'd0;
    localparam logic [2:0] IDX_A2 = 3'd1;
    localparam logic [2:0] IDX_B0 = 3'd2;
    localparam logic [2:0] IDX_B1 = 3'd3;
    localparam logic [2:0] IDX_B2 = 3'd4;

    localparam logic [DEF_W-1:0] DEF_A1 = 25'h1E0A3D7;
    localparam logic [DEF_W-1:0] DEF_A2 = 25'h00F5E35;
    localparam logic [DEF_W-1:0] DEF_B0 = 25'h00000D1;
    localparam logic [DEF_W-1:0] DEF_B1 = 25'h00001A1;
    localparam logic [DEF_W-1:0] DEF_B2 = 25'h00000D1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic logic [DEF_W-1:0] def_coef(input logic [2:0] idx);
        logic [DEF_W-1:0] v;
        case (idx)
            IDX_A1:  v = DEF_A1;
            IDX_A2:  v = DEF_A2;
            IDX_B0:  v = DEF_B0;
            IDX_B1:  v = DEF_B1;
            IDX_B2:  v = DEF_B2;
            default: v = {DEF_W{1'b0}};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coef_regfile.sv
// NPROF x NCOEF coefficient storage with asynchronous read.
// Writable (reset to defaults) when COEF_WRITE_EN is defined, otherwise constant.
module coef_regfile
    import coef_pkg::*;
#(
    parameter int W     = 25,
    parameter int NPROF = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] rd_prof,
    input  logic [2:0]    rd_idx,
    output logic [W-1:0]  rd_data,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_prof,
    input  logic [2:0]    wr_idx,
    input  logic [W-1:0]  wr_data
);

    localparam logic [PW:0] NPROF_W = (PW+1)'(NPROF);

    // Defaults are Q5.20; wider words keep the integer bits and extend the fraction.
    function automatic logic [W-1:0] align(input logic [DEF_W-1:0] d);
        logic [W-1:0] t;
        t = '0;
        t[W-1 -: DEF_W] = d;
        return t;
    endfunction

    logic [W-1:0] bank_s [NPROF][NCOEF];

`ifdef COEF_WRITE_EN
    logic [W-1:0] bank_r [NPROF][NCOEF];
    logic         wr_ok_s;

    assign wr_ok_s = (wr_idx <= IDX_B2) && ({1'b0, wr_prof} < NPROF_W);
    assign bank_s  = bank_r;

    // Coefficient register file; out-of-range writes are silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NPROF; p++) begin
                for (int i = 0; i < NCOEF; i++) begin
                    bank_r[p][i] <= align(def_coef(3'(i)));
                end
            end
        end else if (wr_en && wr_ok_s) begin
            bank_r[wr_prof][wr_idx] <= wr_data;
        end
    end
`else
    logic unused_wr_s;
    assign unused_wr_s = ^{clk, rst_n, wr_en, wr_prof, wr_idx, wr_data};

    // Constant bank: every profile carries the default coefficient set.
    always_comb begin
        for (int p = 0; p < NPROF; p++) begin
            for (int i = 0; i < NCOEF; i++) begin
                bank_s[p][i] = align(def_coef(3'(i)));
            end
        end
    end
`endif

    // Asynchronous read, zero for addresses outside the bank.
    always_comb begin
        rd_data = '0;
        if ((rd_idx <= IDX_B2) && ({1'b0, rd_prof} < NPROF_W)) begin
            rd_data = bank_s[rd_prof][rd_idx];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/coef_bank_seq.sv
// Multi-profile biquad coefficient bank with readout sequencer (a1,a2,b0,b1,b2 per sweep).
// Define COEF_WRITE_EN to make the bank writable through the wr_* port.
module coef_bank_seq
    import coef_pkg::*;
#(
    parameter int W     = 25,
    parameter int NPROF = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [PW-1:0] prof_sel,
    output logic [W-1:0]  coef_out,
    output logic [2:0]    coef_idx,
    output logic          coef_valid,
    output logic          coef_last,
    output logic          busy,
    output logic          overrun,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_prof,
    input  logic [2:0]    wr_idx,
    input  logic [W-1:0]  wr_data,
    output logic          wr_ready
);

    localparam logic [PW:0] NPROF_W = (PW+1)'(NPROF);

    if (W < DEF_W) begin : g_width_check
        $error("coef_bank_seq: W must be at least 25");
    end

    state_e        state_r;
    logic [2:0]    nxt_idx_r;
    logic [PW-1:0] act_prof_r;
    logic [PW-1:0] sel_prof_s;
    logic [PW-1:0] rd_prof_s;
    logic [2:0]    rd_idx_s;
    logic [W-1:0]  rd_data_s;
    logic          wr_accept_s;

`ifdef COEF_WRITE_EN
    // Only the profile currently being streamed is locked against writes.
    assign wr_ready = !(busy && (wr_prof == act_prof_r));
`else
    assign wr_ready = 1'b0;
`endif
    assign wr_accept_s = wr_en && wr_ready;

    // Read address: first coefficient of the requested profile while idle, else the sweep cursor.
    always_comb begin
        sel_prof_s = '0;
        rd_prof_s  = '0;
        rd_idx_s   = IDX_A1;
        if ({1'b0, prof_sel} < NPROF_W) begin
            sel_prof_s = prof_sel;
        end else begin
            sel_prof_s = '0;
        end
        if (state_r == IDLE) begin
            rd_prof_s = sel_prof_s;
            rd_idx_s  = IDX_A1;
        end else begin
            rd_prof_s = act_prof_r;
            rd_idx_s  = nxt_idx_r;
        end
    end

    coef_regfile #(
        .W     (W),
        .NPROF (NPROF),
        .PW    (PW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_prof (rd_prof_s),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s),
        .wr_en   (wr_accept_s),
        .wr_prof (wr_prof),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

    // Sweep sequencer; a1 is registered on the accepting edge so it is valid the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            nxt_idx_r  <= 3'd0;
            act_prof_r <= '0;
            coef_out   <= '0;
            coef_idx   <= 3'd0;
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= start && busy;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        act_prof_r <= sel_prof_s;
                        coef_out   <= rd_data_s;
                        coef_idx   <= IDX_A1;
                        coef_valid <= 1'b1;
                        coef_last  <= 1'b0;
                        busy       <= 1'b1;
                        nxt_idx_r  <= IDX_A2;
                        state_r    <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (coef_last) begin
                        coef_valid <= 1'b0;
                        coef_last  <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        coef_out  <= rd_data_s;
                        coef_idx  <= nxt_idx_r;
                        coef_last <= (nxt_idx_r == IDX_B2);
                        nxt_idx_r <= nxt_idx_r + 3'd1;
                    end
                end
                default: begin
                    coef_valid <= 1'b0;
                    coef_last  <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coef_bank_seq.sv
// Scoreboard bench for coef_bank_seq: random and directed sweeps checked against a
// coefficient-array reference model; write checks are active when COEF_WRITE_EN is defined.
module tb_coef_bank_seq;

    localparam int W     = 25;
    localparam int NPROF = 4;
    localparam int PW    = 2;
`ifdef COEF_WRITE_EN
    localparam bit WREN = 1'b1;
`else
    localparam bit WREN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] prof_sel = '0;
    logic [W-1:0]  coef_out;
    logic [2:0]    coef_idx;
    logic          coef_valid;
    logic          coef_last;
    logic          busy;
    logic          overrun;
    logic          wr_en = 1'b0;
    logic [PW-1:0] wr_prof = '0;
    logic [2:0]    wr_idx = 3'd0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_ready;

    always #5 clk = ~clk;

    coef_bank_seq #(.W(W), .NPROF(NPROF), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prof_sel(prof_sel),
        .coef_out(coef_out), .coef_idx(coef_idx), .coef_valid(coef_valid),
        .coef_last(coef_last), .busy(busy), .overrun(overrun),
        .wr_en(wr_en), .wr_prof(wr_prof), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_ready(wr_ready)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   idx;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           ovr_q[$];
    logic [W-1:0] model [NPROF][5];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           b_start = -10;
    int           b_end = -10;
    int           m_act = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] spec_default(input int i);
        case (i)
            0:       return 25'h1E0A3D7;
            1:       return 25'h00F5E35;
            2:       return 25'h00000D1;
            3:       return 25'h00001A1;
            default: return 25'h00000D1;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPROF; p++)
            for (int i = 0; i < 5; i++)
                model[p][i] = spec_default(i);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the sweep, overrun and write effects.
    task automatic step(input bit st, input int ps, input bit we, input int wp, input int wi,
                        input logic [W-1:0] wd);
        bit m_busy;
        bit m_ready;
        start    = st;
        prof_sel = PW'(ps);
        wr_en    = we;
        wr_prof  = PW'(wp);
        wr_idx   = 3'(wi);
        wr_data  = wd;
        #1;
        m_busy  = (cyc >= b_start) && (cyc <= b_end);
        m_ready = WREN && !(m_busy && (wp == m_act));
        check("wr_ready", {63'd0, wr_ready}, {63'd0, m_ready});
        if (st) begin
            if (m_busy) begin
                ovr_q.push_back(cyc + 1);
            end else begin
                m_act   = (ps < NPROF) ? ps : 0;
                b_start = cyc + 1;
                b_end   = cyc + 5;
                for (int i = 0; i < 5; i++)
                    exp_q.push_back('{model[m_act][i], 3'(i), (i == 4)});
            end
        end
        if (we && m_ready && (wi < 5) && (wp < NPROF))
            model[wp][wi] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 0, 0, '0);
    endtask

    // Monitor: compares every presented beat and the busy/overrun flags against the model.
    always @(negedge clk) begin : monitor
        bit    eb;
        bit    eo;
        beat_t b;
        if (rst_n) begin
            eb = (cyc >= b_start) && (cyc <= b_end);
            check("busy", {63'd0, busy}, {63'd0, eb});
            check("coef_valid", {63'd0, coef_valid}, {63'd0, eb});
            eo = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
            if (eo) void'(ovr_q.pop_front());
            check("overrun", {63'd0, overrun}, {63'd0, eo});
            if (coef_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat at cycle %0d: actual idx=%0d data=%0h required no beat",
                             cyc, coef_idx, coef_out);
                end else begin
                    b = exp_q.pop_front();
                    check("coef_out", {39'd0, coef_out}, {39'd0, b.data});
                    check("coef_idx", {61'd0, coef_idx}, {61'd0, b.idx});
                    check("coef_last", {63'd0, coef_last}, {63'd0, b.last});
                end
            end else begin
                check("coef_last_idle", {63'd0, coef_last}, 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_coef_out"}, {39'd0, coef_out}, 64'd0);
        check({tag, "_coef_idx"}, {61'd0, coef_idx}, 64'd0);
        check({tag, "_coef_valid"}, {63'd0, coef_valid}, 64'd0);
        check({tag, "_coef_last"}, {63'd0, coef_last}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_overrun"}, {63'd0, overrun}, 64'd0);
    endtask

    initial begin
        bit st;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default sweep of profile 0.
        step(1'b1, 0, 1'b0, 0, 0, '0);
        idle(6);

        // Start at +2 of a sweep is ignored and flagged.
        step(1'b1, 1, 1'b0, 0, 0, '0);
        step(1'b0, 0, 1'b0, 0, 0, '0);
        step(1'b1, 2, 1'b0, 0, 0, '0);
        idle(6);

        // Write profile 2 a2, then sweep profiles 2 and 0.
        step(1'b0, 0, 1'b1, 2, 1, 25'h0123456);
        step(1'b1, 2, 1'b0, 0, 0, '0);
        idle(6);
        step(1'b1, 0, 1'b0, 0, 0, '0);
        idle(6);

        // Writes to the active profile stall; writes elsewhere go through.
        step(1'b1, 1, 1'b0, 0, 0, '0);
        step(1'b0, 0, 1'b1, 1, 0, 25'h1555555);
        step(1'b0, 0, 1'b1, 1, 0, 25'h1555555);
        step(1'b0, 0, 1'b1, 3, 4, 25'h0AAAAAA);
        step(1'b0, 0, 1'b1, 1, 3, 25'h0777777);
        idle(3);
        step(1'b0, 0, 1'b1, 1, 0, 25'h1555555);
        step(1'b1, 1, 1'b0, 0, 0, '0);
        idle(6);
        step(1'b1, 3, 1'b0, 0, 0, '0);
        idle(6);

        // Out-of-range write index is accepted but dropped.
        step(1'b0, 0, 1'b1, 0, 6, 25'h1FFFFFF);
        step(1'b1, 0, 1'b0, 0, 0, '0);
        idle(6);

        // Back-to-back sweeps at the maximum rate.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, k, 1'b0, 0, 0, '0);
            idle(5);
        end
        idle(2);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(2) == 0);
            step(st, int'($urandom_range(NPROF - 1)), (!st) && ($urandom_range(1) == 1),
                 int'($urandom_range(NPROF - 1)), int'($urandom_range(7)), W'($urandom));
        end
        idle(7);

        // Reset mid-sweep clears outputs at once and restores default coefficients.
        step(1'b0, 0, 1'b1, 2, 1, 25'h0123456);
        step(1'b1, 2, 1'b0, 0, 0, '0);
        step(1'b0, 0, 1'b0, 0, 0, '0);
        step(1'b0, 0, 1'b0, 0, 0, '0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        ovr_q.delete();
        model_reset();
        b_start = -10;
        b_end   = -10;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        step(1'b1, 2, 1'b0, 0, 0, '0);
        idle(8);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("overrun_q_empty", 64'(ovr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
